// File: rtl/rx_reg_bank_if.sv
// rtl/rx_reg_bank_if.sv - deserializer word bus and stream output bundle for rx_reg_bank
//
// Purpose: groups the deserializer parallel-word input (P_ADDR/P_DATA/P_ENA)
// and the stream FIFO output handshake (STRM_DATA/STRM_VALID/STRM_READY).
// Modports:
//   master - environment side: drives the word bus and STRM_READY
//   slave  - rx_reg_bank side: consumes the word bus, drives the stream head
interface rx_reg_bank_if;
  logic [2:0]  P_ADDR;
  logic [15:0] P_DATA;
  logic        P_ENA;
  logic [15:0] STRM_DATA;
  logic        STRM_VALID;
  logic        STRM_READY;

  modport master (
    output P_ADDR, P_DATA, P_ENA, STRM_READY,
    input  STRM_DATA, STRM_VALID
  );

  modport slave (
    input  P_ADDR, P_DATA, P_ENA, STRM_READY,
    output STRM_DATA, STRM_VALID
  );
endinterface

// File: rtl/rx_reg_bank.sv
// rtl/rx_reg_bank.sv - config register bank and stream splitter behind the deserializer
//
// Purpose: decodes deserializer words into double-buffered config registers
// (addr 0-5), a first-word-fall-through stream FIFO (addr 6) and a control
// register (addr 7: bit0 commit, bit1 flush, bit2 clear counters).
// Ports:
//   RX_CLK    - clock
//   RST       - asynchronous active-low reset
//   p_if      - word bus in (P_ADDR/P_DATA/P_ENA), stream out (STRM_*)
//   CFG_OUT   - active config regs, reg n at [16n+15:16n]
//   UPDATE    - one-cycle pulse after a commit
//   WORD_CNT  - accepted write events, wraps
//   OVF_CNT   - stream words dropped on full FIFO, saturates at 255
module rx_reg_bank #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             RX_CLK,
  input  logic             RST,
  rx_reg_bank_if.slave     p_if,
  output logic [95:0]      CFG_OUT,
  output logic             UPDATE,
  output logic [CNT_W-1:0] WORD_CNT,
  output logic [7:0]       OVF_CNT
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic             p_ena_d_q, p_ena_d_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [15:0]      mem_d [FIFO_DEPTH];
  logic [15:0]      shadow_q [6];
  logic [15:0]      shadow_d [6];
  logic [15:0]      active_q [6];
  logic [15:0]      active_d [6];
  logic             update_q, update_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [7:0]       ovf_cnt_q, ovf_cnt_d;

  logic wr_event, fifo_empty, fifo_full, pop, push_req, push_ok;
  logic ctrl_wr, commit, flush, clr_cnt;

  always_comb begin
    wr_event   = p_if.P_ENA & ~p_ena_d_q;
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    // Extra pointer bit distinguishes full from empty when the index bits match.
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = ~fifo_empty & p_if.STRM_READY;
    push_req   = wr_event && (p_if.P_ADDR == 3'd6);
    // A pop on the same edge frees the slot the push lands in.
    push_ok    = push_req && (~fifo_full || pop);
    ctrl_wr    = wr_event && (p_if.P_ADDR == 3'd7);
    commit     = ctrl_wr & p_if.P_DATA[0];
    flush      = ctrl_wr & p_if.P_DATA[1];
    clr_cnt    = ctrl_wr & p_if.P_DATA[2];
  end

  always_comb begin
    p_ena_d_d  = p_if.P_ENA;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    update_d   = commit;
    word_cnt_d = word_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    for (int i = 0; i < 6; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = commit ? shadow_q[i] : active_q[i];
      if (wr_event && (p_if.P_ADDR == 3'(i))) shadow_d[i] = p_if.P_DATA;
    end

    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = p_if.P_DATA;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    // Flush overrides any pop on the same edge.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    if (push_req && !push_ok && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;

    // The clearing control word is not itself counted.
    if (clr_cnt) begin
      word_cnt_d = '0;
      ovf_cnt_d  = '0;
    end else if (wr_event) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge RX_CLK or negedge RST) begin
    if (!RST) begin
      p_ena_d_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      update_q   <= 1'b0;
      word_cnt_q <= '0;
      ovf_cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      p_ena_d_q  <= p_ena_d_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      update_q   <= update_d;
      word_cnt_q <= word_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 6; i++) CFG_OUT[16*i +: 16] = active_q[i];
  end

  assign UPDATE          = update_q;
  assign WORD_CNT        = word_cnt_q;
  assign OVF_CNT         = ovf_cnt_q;
  assign p_if.STRM_VALID = ~fifo_empty;
  assign p_if.STRM_DATA  = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: tb/tb_rx_reg_bank.sv
// tb/tb_rx_reg_bank.sv - scoreboard testbench for rx_reg_bank
module tb_rx_reg_bank;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             RX_CLK = 1'b0;
  logic             RST;
  logic [95:0]      CFG_OUT;
  logic             UPDATE;
  logic [CNT_W-1:0] WORD_CNT;
  logic [7:0]       OVF_CNT;

  rx_reg_bank_if bus ();

  rx_reg_bank #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .RX_CLK   (RX_CLK),
    .RST      (RST),
    .p_if     (bus),
    .CFG_OUT  (CFG_OUT),
    .UPDATE   (UPDATE),
    .WORD_CNT (WORD_CNT),
    .OVF_CNT  (OVF_CNT)
  );

  always #5 RX_CLK = ~RX_CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_ready = 0;

  // Reference model state
  logic [15:0] m_shadow [6];
  logic [15:0] m_active [6];
  bit          m_update;
  int          m_wc, m_ovf, m_occ;
  bit          m_prev;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] model_cfg();
    logic [95:0] v;
    for (int i = 0; i < 6; i++) v[16*i +: 16] = m_active[i];
    return v;
  endfunction

  // Model: advances on each clock edge from the driven inputs only.
  initial begin
    bit ev, pop;
    forever begin
      @(posedge RX_CLK or negedge RST);
      if (!RST) begin
        for (int i = 0; i < 6; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
        m_update = 0; m_wc = 0; m_ovf = 0; m_occ = 0; m_prev = 0;
        exp_q.delete();
      end else begin
        ev = bus.P_ENA && !m_prev;
        m_prev = bus.P_ENA;
        pop = (m_occ > 0) && bus.STRM_READY;
        m_update = 0;
        if (pop) m_occ--;
        if (ev) begin
          if (bus.P_ADDR < 6) begin
            m_shadow[bus.P_ADDR] = bus.P_DATA;
            m_wc = (m_wc + 1) % (1 << CNT_W);
          end else if (bus.P_ADDR == 6) begin
            if (m_occ < DEPTH) begin
              exp_q.push_back(bus.P_DATA);
              m_occ++;
            end else if (m_ovf < 255) begin
              m_ovf++;
            end
            m_wc = (m_wc + 1) % (1 << CNT_W);
          end else begin
            if (bus.P_DATA[2]) begin m_wc = 0; m_ovf = 0; end
            else m_wc = (m_wc + 1) % (1 << CNT_W);
            if (bus.P_DATA[0]) begin
              for (int i = 0; i < 6; i++) m_active[i] = m_shadow[i];
              m_update = 1;
            end
            if (bus.P_DATA[1]) begin
              while (m_occ > 0) begin
                exp_q.delete(exp_q.size() - 1);
                m_occ--;
              end
            end
          end
        end
      end
    end
  end

  // Monitor: compares outputs mid-cycle and scores each pop.
  initial begin
    forever begin
      @(negedge RX_CLK);
      chk("cfg_out", CFG_OUT, model_cfg());
      chk("update", 96'(UPDATE), 96'(m_update));
      chk("word_cnt", 96'(WORD_CNT), 96'(m_wc));
      chk("ovf_cnt", 96'(OVF_CNT), 96'(m_ovf));
      chk("strm_valid", 96'(bus.STRM_VALID), 96'(m_occ > 0));
      if (bus.STRM_VALID && bus.STRM_READY) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 96'(bus.STRM_DATA), 96'hDEAD_0000);
        else chk("pop_data", 96'(bus.STRM_DATA), 96'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge RX_CLK);
    #1;
    if (rand_ready) bus.STRM_READY = 1'($urandom_range(0, 1));
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input int hold = 1, input int gap = 1);
    bus.P_ADDR = a;
    bus.P_DATA = d;
    bus.P_ENA  = 1'b1;
    repeat (hold) tick();
    bus.P_ENA  = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    logic [15:0] cw;
    RST = 1'b0;
    bus.P_ADDR = 0; bus.P_DATA = 0; bus.P_ENA = 0; bus.STRM_READY = 0;
    #12;
    chk("rst_cfg", CFG_OUT, 96'h0);
    chk("rst_valid", 96'(bus.STRM_VALID), 96'h0);
    chk("rst_wc", 96'(WORD_CNT), 96'h0);
    RST = 1'b1;
    tick();

    // Shadow then commit
    wr(3'd2, 16'hBEEF);
    chk("shadow_hidden", 96'(CFG_OUT[47:32]), 96'h0);
    bus.P_ADDR = 3'd7; bus.P_DATA = 16'h0001; bus.P_ENA = 1'b1;
    tick();
    chk("commit_cfg", 96'(CFG_OUT[47:32]), 96'hBEEF);
    chk("commit_update", 96'(UPDATE), 96'h1);
    chk("commit_wc", 96'(WORD_CNT), 96'h2);
    bus.P_ENA = 1'b0;
    tick();
    chk("update_drop", 96'(UPDATE), 96'h0);

    // Held strobe counts once
    wr(3'd7, 16'h0004);
    wr(3'd6, 16'h1234, 10, 1);
    chk("held_valid", 96'(bus.STRM_VALID), 96'h1);
    chk("held_data", 96'(bus.STRM_DATA), 96'h1234);
    chk("held_wc", 96'(WORD_CNT), 96'h1);
    bus.STRM_READY = 1; tick(); bus.STRM_READY = 0; tick();

    // Overflow
    wr(3'd7, 16'h0004);
    for (int v = 1; v <= 6; v++) wr(3'd6, 16'(v));
    chk("ovf_cnt2", 96'(OVF_CNT), 96'h2);
    chk("ovf_head", 96'(bus.STRM_DATA), 96'h1);
    bus.STRM_READY = 1; repeat (5) tick(); bus.STRM_READY = 0;
    chk("ovf_drained", 96'(bus.STRM_VALID), 96'h0);

    // Full push with simultaneous pop
    wr(3'd7, 16'h0004);
    for (int v = 1; v <= 4; v++) wr(3'd6, 16'(v));
    bus.P_ADDR = 3'd6; bus.P_DATA = 16'd5; bus.P_ENA = 1'b1; bus.STRM_READY = 1'b1;
    tick();
    bus.P_ENA = 1'b0; bus.STRM_READY = 1'b0;
    tick();
    chk("fullpop_ovf", 96'(OVF_CNT), 96'h0);
    chk("fullpop_head", 96'(bus.STRM_DATA), 96'h2);
    bus.STRM_READY = 1; repeat (5) tick(); bus.STRM_READY = 0;

    // Flush and clear with 3 words queued and a nonzero drop count
    for (int v = 1; v <= 5; v++) wr(3'd6, 16'(16'h40 + v));
    bus.STRM_READY = 1; tick(); bus.STRM_READY = 0; tick();
    chk("pre_flush_ovf", 96'(OVF_CNT), 96'h1);
    bus.P_ADDR = 3'd7; bus.P_DATA = 16'h0006; bus.P_ENA = 1'b1;
    tick();
    chk("flush_valid", 96'(bus.STRM_VALID), 96'h0);
    chk("flush_wc", 96'(WORD_CNT), 96'h0);
    chk("flush_ovf", 96'(OVF_CNT), 96'h0);
    bus.P_ENA = 1'b0; tick();

    // Async reset mid-stream, strobe held high across release
    wr(3'd0, 16'hA5A5);
    wr(3'd7, 16'h0001);
    wr(3'd6, 16'h0007);
    wr(3'd6, 16'h0008);
    @(posedge RX_CLK); #2;
    RST = 1'b0;
    #1;
    chk("arst_cfg", CFG_OUT, 96'h0);
    chk("arst_update", 96'(UPDATE), 96'h0);
    chk("arst_valid", 96'(bus.STRM_VALID), 96'h0);
    chk("arst_wc", 96'(WORD_CNT), 96'h0);
    chk("arst_ovf", 96'(OVF_CNT), 96'h0);
    bus.P_ADDR = 3'd6; bus.P_DATA = 16'h0009; bus.P_ENA = 1'b1;
    @(posedge RX_CLK); #1;
    RST = 1'b1;
    tick();
    bus.P_ENA = 1'b0;
    tick();
    chk("rel_valid", 96'(bus.STRM_VALID), 96'h1);
    chk("rel_data", 96'(bus.STRM_DATA), 96'h9);
    bus.STRM_READY = 1; tick(); bus.STRM_READY = 0; tick();

    // Randomized traffic, consumer readiness randomized every cycle
    rand_ready = 1;
    repeat (400) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        wr(3'($urandom_range(0, 5)), 16'($urandom), $urandom_range(1, 3), $urandom_range(1, 2));
      end else if (op <= 7) begin
        wr(3'd6, 16'($urandom), $urandom_range(1, 3), $urandom_range(1, 2));
      end else begin
        cw = 16'($urandom);
        if (cw[1] == 1'b0 || $urandom_range(0, 2) == 0) begin
          if (cw[0]) wr(3'd0, m_active[0] ^ 16'h8001);
          wr(3'd7, cw, $urandom_range(1, 3), $urandom_range(1, 2));
        end
      end
    end
    rand_ready = 0;
    bus.STRM_READY = 1;
    repeat (DEPTH + 2) tick();
    bus.STRM_READY = 0;
    tick();
    chk("final_drained", 96'(exp_q.size()), 96'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
